host_mailbox: RTL and testbench

- Bidirectional byte mailbox between the C64 host (I/O2 window, $DFF8-$DFFB) and the cartridge coprocessor.
- Contains two FIFOs: host-to-cocpu (h2c) and cocpu-to-host (c2h).
- Drives the coprocessor interrupt line, which the top level currently ties inactive, and an optional host interrupt.
- Sits beside the bank/reset registers at $DFFC-$DFFF. The top-level decode supplies select strobes; the top level owns the data-bus tristate muxing.

---
 rtl/host_mailbox_pkg.sv | 41 ++++
 rtl/host_mailbox_fifo.sv | 67 ++++++
 rtl/host_mailbox.sv | 138 +++++++++++++
 tb/tb_host_mailbox.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/host_mailbox_pkg.sv
// Shared definitions for the host/coprocessor byte mailbox: register offsets,
// STATUS/CTRL bit positions and the STATUS byte builder used by both sides.
package host_mailbox_pkg;

  localparam int MBX_DW = 8;

  typedef enum logic [1:0] {
    MBX_DATA   = 2'd0,
    MBX_STATUS = 2'd1,
    MBX_CTRL   = 2'd2,
    MBX_COUNT  = 2'd3
  } mbx_reg_e;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_UNDERFLOW = 2;
  localparam int ST_TX_OVERFLOW  = 3;
  localparam int ST_IRQ_EN       = 7;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // address_cpu[7:2] value that selects the mailbox inside the I/O2 page
  localparam logic [5:0] HOST_WINDOW_BASE = 6'b111110;

  function automatic logic [MBX_DW-1:0] mbx_status(input logic rxNonEmpty,
                                                   input logic txFull,
                                                   input logic rxUf,
                                                   input logic txOvf,
                                                   input logic irqEn);
    logic [MBX_DW-1:0] s;
    s                  = '0;
    s[ST_RX_NONEMPTY]  = rxNonEmpty;
    s[ST_TX_FULL]      = txFull;
    s[ST_RX_UNDERFLOW] = rxUf;
    s[ST_TX_OVERFLOW]  = txOvf;
    s[ST_IRQ_EN]       = irqEn;
    return s;
  endfunction

endpackage

// File: rtl/host_mailbox_fifo.sv
// Byte FIFO with occupancy counter; a pop frees a slot for a push on a full
// FIFO at the same edge, and flush overrides both without touching storage.
module sync_fifo
  import host_mailbox_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [MBX_DW-1:0] din_i,
  output logic [MBX_DW-1:0] dout_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              push_ok_o,
  output logic              pop_ok_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [MBX_DW-1:0] mem_q [DEPTH];

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign pop_ok_o  = pop_i & ~empty_o;
  assign push_ok_o = push_i & (~full_o | pop_ok_o);
  assign dout_o    = mem_q[rdPtr_q];
  assign count_o   = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_ok_o) wrPtr_d = wrPtr_q + PW'(1);
      if (pop_ok_o)  rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + CW'(push_ok_o) - CW'(pop_ok_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o && !flush_i) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/host_mailbox.sv
// Bidirectional host/coprocessor mailbox: two FIFOs, per-side register decode,
// sticky error flags and registered active-low interrupts.
module host_mailbox
  import host_mailbox_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clock_cpu,
  input  logic       _reset_cpu,
  input  logic       host_sel,
  input  logic [1:0] host_addr,
  input  logic       host_r_w,
  input  logic [7:0] host_data_in,
  output logic [7:0] host_data_out,
  output logic       host_data_oe,
  input  logic       cocpu_sel,
  input  logic [1:0] cocpu_addr,
  input  logic       cocpu_r_w,
  input  logic [7:0] cocpu_data_in,
  output logic [7:0] cocpu_data_out,
  output logic       cocpu_data_oe,
  output logic       _irq_cocpu,
  output logic       _irq_host
);

  logic hostDataRd, hostDataWr, hostStatusRd, hostCtrlWr;
  logic cocpuDataRd, cocpuDataWr, cocpuStatusRd, cocpuCtrlWr;
  logic flush;

  logic [7:0]    h2cDout, c2hDout;
  logic [CW-1:0] h2cCount, c2hCount, h2cCountNext, c2hCountNext;
  logic          h2cFull, h2cEmpty, h2cPushOk, h2cPopOk;
  logic          c2hFull, c2hEmpty, c2hPushOk, c2hPopOk;

  logic hostUf_q, hostUf_d, hostOvf_q, hostOvf_d;
  logic cocpuUf_q, cocpuUf_d, cocpuOvf_q, cocpuOvf_d;
  logic hostIrqEn_q, hostIrqEn_d, cocpuIrqEn_q, cocpuIrqEn_d;
  logic irqHost_q, irqHost_d, irqCocpu_q, irqCocpu_d;

  assign hostDataRd    = host_sel & host_r_w & (host_addr == MBX_DATA);
  assign hostDataWr    = host_sel & ~host_r_w & (host_addr == MBX_DATA);
  assign hostStatusRd  = host_sel & host_r_w & (host_addr == MBX_STATUS);
  assign hostCtrlWr    = host_sel & ~host_r_w & (host_addr == MBX_CTRL);
  assign cocpuDataRd   = cocpu_sel & cocpu_r_w & (cocpu_addr == MBX_DATA);
  assign cocpuDataWr   = cocpu_sel & ~cocpu_r_w & (cocpu_addr == MBX_DATA);
  assign cocpuStatusRd = cocpu_sel & cocpu_r_w & (cocpu_addr == MBX_STATUS);
  assign cocpuCtrlWr   = cocpu_sel & ~cocpu_r_w & (cocpu_addr == MBX_CTRL);

  assign flush = (hostCtrlWr & host_data_in[CTRL_FLUSH]) |
                 (cocpuCtrlWr & cocpu_data_in[CTRL_FLUSH]);

  assign host_data_oe  = host_sel & host_r_w;
  assign cocpu_data_oe = cocpu_sel & cocpu_r_w;
  assign _irq_host     = irqHost_q;
  assign _irq_cocpu    = irqCocpu_q;

  sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_h2c (
    .clk_i(clock_cpu), .rst_ni(_reset_cpu),
    .push_i(hostDataWr), .pop_i(cocpuDataRd), .flush_i(flush), .din_i(host_data_in),
    .dout_o(h2cDout), .count_o(h2cCount), .full_o(h2cFull), .empty_o(h2cEmpty),
    .push_ok_o(h2cPushOk), .pop_ok_o(h2cPopOk)
  );

  sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_c2h (
    .clk_i(clock_cpu), .rst_ni(_reset_cpu),
    .push_i(cocpuDataWr), .pop_i(hostDataRd), .flush_i(flush), .din_i(cocpu_data_in),
    .dout_o(c2hDout), .count_o(c2hCount), .full_o(c2hFull), .empty_o(c2hEmpty),
    .push_ok_o(c2hPushOk), .pop_ok_o(c2hPopOk)
  );

  // A new error at the same edge as a STATUS read survives the clear
  always_comb begin
    hostUf_d     = (hostUf_q & ~hostStatusRd) | (hostDataRd & ~c2hPopOk);
    hostOvf_d    = (hostOvf_q & ~hostStatusRd) | (hostDataWr & ~h2cPushOk);
    cocpuUf_d    = (cocpuUf_q & ~cocpuStatusRd) | (cocpuDataRd & ~h2cPopOk);
    cocpuOvf_d   = (cocpuOvf_q & ~cocpuStatusRd) | (cocpuDataWr & ~c2hPushOk);
    hostIrqEn_d  = hostCtrlWr ? host_data_in[CTRL_IRQ_EN] : hostIrqEn_q;
    cocpuIrqEn_d = cocpuCtrlWr ? cocpu_data_in[CTRL_IRQ_EN] : cocpuIrqEn_q;
    h2cCountNext = h2cCount + CW'(h2cPushOk) - CW'(h2cPopOk);
    c2hCountNext = c2hCount + CW'(c2hPushOk) - CW'(c2hPopOk);
    if (flush) begin
      hostUf_d     = 1'b0;
      hostOvf_d    = 1'b0;
      cocpuUf_d    = 1'b0;
      cocpuOvf_d   = 1'b0;
      h2cCountNext = '0;
      c2hCountNext = '0;
    end
    irqCocpu_d = ~(cocpuIrqEn_d & (h2cCountNext != '0));
    irqHost_d  = ~(hostIrqEn_d & (c2hCountNext != '0));
  end

  always_ff @(posedge clock_cpu or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      hostUf_q     <= 1'b0;
      hostOvf_q    <= 1'b0;
      cocpuUf_q    <= 1'b0;
      cocpuOvf_q   <= 1'b0;
      hostIrqEn_q  <= 1'b0;
      cocpuIrqEn_q <= 1'b0;
      irqHost_q    <= 1'b1;
      irqCocpu_q   <= 1'b1;
    end else begin
      hostUf_q     <= hostUf_d;
      hostOvf_q    <= hostOvf_d;
      cocpuUf_q    <= cocpuUf_d;
      cocpuOvf_q   <= cocpuOvf_d;
      hostIrqEn_q  <= hostIrqEn_d;
      cocpuIrqEn_q <= cocpuIrqEn_d;
      irqHost_q    <= irqHost_d;
      irqCocpu_q   <= irqCocpu_d;
    end
  end

  always_comb begin
    host_data_out = '0;
    case (host_addr)
      MBX_DATA:   host_data_out = c2hEmpty ? 8'h00 : c2hDout;
      MBX_STATUS: host_data_out = mbx_status(~c2hEmpty, h2cFull, hostUf_q, hostOvf_q, hostIrqEn_q);
      MBX_CTRL:   host_data_out[CTRL_IRQ_EN] = hostIrqEn_q;
      MBX_COUNT:  host_data_out = 8'(c2hCount);
      default:    host_data_out = '0;
    endcase
  end

  always_comb begin
    cocpu_data_out = '0;
    case (cocpu_addr)
      MBX_DATA:   cocpu_data_out = h2cEmpty ? 8'h00 : h2cDout;
      MBX_STATUS: cocpu_data_out = mbx_status(~h2cEmpty, c2hFull, cocpuUf_q, cocpuOvf_q, cocpuIrqEn_q);
      MBX_CTRL:   cocpu_data_out[CTRL_IRQ_EN] = cocpuIrqEn_q;
      MBX_COUNT:  cocpu_data_out = 8'(h2cCount);
      default:    cocpu_data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_host_mailbox.sv
// Self-checking bench for host_mailbox: queue-based mailbox model checked every
// cycle, plus directed register reads with hand-computed literal values.
module tb_host_mailbox;

  localparam int DEPTH = 16;

  logic       clock_cpu = 1'b0;
  logic       _reset_cpu = 1'b0;
  logic       host_sel = 1'b0, host_r_w = 1'b1;
  logic [1:0] host_addr = 2'd0;
  logic [7:0] host_data_in = 8'h00;
  logic       cocpu_sel = 1'b0, cocpu_r_w = 1'b1;
  logic [1:0] cocpu_addr = 2'd0;
  logic [7:0] cocpu_data_in = 8'h00;
  logic [7:0] host_data_out, cocpu_data_out;
  logic       host_data_oe, cocpu_data_oe, _irq_cocpu, _irq_host;

  int checks = 0;
  int errors = 0;

  logic [7:0] h2cQ[$];
  logic [7:0] c2hQ[$];
  bit hostUf, hostOvf, cocpuUf, cocpuOvf, hostEn, cocpuEn;
  bit expIrqCocpu = 1'b1, expIrqHost = 1'b1;
  bit compareOn = 1'b0;
  bit hDR, hDW, hSR, hCW, cDR, cDW, cSR, cCW, doFlush;
  bit h2cPop, c2hPop, h2cPush, c2hPush;

  always #5 clock_cpu = ~clock_cpu;

  host_mailbox #(.DEPTH(DEPTH)) dut (
    .clock_cpu(clock_cpu), ._reset_cpu(_reset_cpu),
    .host_sel(host_sel), .host_addr(host_addr), .host_r_w(host_r_w),
    .host_data_in(host_data_in), .host_data_out(host_data_out), .host_data_oe(host_data_oe),
    .cocpu_sel(cocpu_sel), .cocpu_addr(cocpu_addr), .cocpu_r_w(cocpu_r_w),
    .cocpu_data_in(cocpu_data_in), .cocpu_data_out(cocpu_data_out), .cocpu_data_oe(cocpu_data_oe),
    ._irq_cocpu(_irq_cocpu), ._irq_host(_irq_host)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  // What a read of a register must return, from the model's current contents
  function automatic logic [7:0] modelRead(input bit isHost, input logic [1:0] addr);
    int rxSize, txSize;
    logic [7:0] head, v;
    bit uf, ovf, en;
    rxSize = isHost ? c2hQ.size() : h2cQ.size();
    txSize = isHost ? h2cQ.size() : c2hQ.size();
    head   = (rxSize == 0) ? 8'h00 : (isHost ? c2hQ[0] : h2cQ[0]);
    uf     = isHost ? hostUf : cocpuUf;
    ovf    = isHost ? hostOvf : cocpuOvf;
    en     = isHost ? hostEn : cocpuEn;
    case (addr)
      2'd0:    v = head;
      2'd1:    v = {en, 3'b000, ovf, uf, (txSize == DEPTH), (rxSize != 0)};
      2'd2:    v = {6'b0, en, 1'b0};
      default: v = rxSize[7:0];
    endcase
    return v;
  endfunction

  // Model update at each edge from the inputs presented during the cycle
  always @(posedge clock_cpu or negedge _reset_cpu) begin
    if (!_reset_cpu) begin
      h2cQ.delete();
      c2hQ.delete();
      {hostUf, hostOvf, cocpuUf, cocpuOvf, hostEn, cocpuEn} = '0;
      expIrqCocpu = 1'b1;
      expIrqHost  = 1'b1;
    end else begin
      hDR = host_sel && host_r_w && host_addr == 2'd0;
      hDW = host_sel && !host_r_w && host_addr == 2'd0;
      hSR = host_sel && host_r_w && host_addr == 2'd1;
      hCW = host_sel && !host_r_w && host_addr == 2'd2;
      cDR = cocpu_sel && cocpu_r_w && cocpu_addr == 2'd0;
      cDW = cocpu_sel && !cocpu_r_w && cocpu_addr == 2'd0;
      cSR = cocpu_sel && cocpu_r_w && cocpu_addr == 2'd1;
      cCW = cocpu_sel && !cocpu_r_w && cocpu_addr == 2'd2;
      doFlush = (hCW && host_data_in[0]) || (cCW && cocpu_data_in[0]);
      if (hCW) hostEn = host_data_in[1];
      if (cCW) cocpuEn = cocpu_data_in[1];
      if (doFlush) begin
        h2cQ.delete();
        c2hQ.delete();
        {hostUf, hostOvf, cocpuUf, cocpuOvf} = '0;
      end else begin
        h2cPop  = cDR && h2cQ.size() > 0;
        c2hPop  = hDR && c2hQ.size() > 0;
        h2cPush = hDW && (h2cQ.size() < DEPTH || h2cPop);
        c2hPush = cDW && (c2hQ.size() < DEPTH || c2hPop);
        if (hSR) {hostUf, hostOvf} = 2'b00;
        if (cSR) {cocpuUf, cocpuOvf} = 2'b00;
        if (hDR && !c2hPop) hostUf = 1'b1;
        if (hDW && !h2cPush) hostOvf = 1'b1;
        if (cDR && !h2cPop) cocpuUf = 1'b1;
        if (cDW && !c2hPush) cocpuOvf = 1'b1;
        if (h2cPop) void'(h2cQ.pop_front());
        if (c2hPop) void'(c2hQ.pop_front());
        if (h2cPush) h2cQ.push_back(host_data_in);
        if (c2hPush) c2hQ.push_back(cocpu_data_in);
      end
      expIrqCocpu = !(cocpuEn && h2cQ.size() != 0);
      expIrqHost  = !(hostEn && c2hQ.size() != 0);
    end
  end

  // Cycle-by-cycle comparison against the model, mid-cycle away from the edge
  always @(negedge clock_cpu) begin
    if (compareOn) begin
      checkOutput("irq_cocpu", {7'b0, _irq_cocpu}, {7'b0, expIrqCocpu});
      checkOutput("irq_host", {7'b0, _irq_host}, {7'b0, expIrqHost});
      checkOutput("host_oe", {7'b0, host_data_oe}, {7'b0, host_sel & host_r_w});
      checkOutput("cocpu_oe", {7'b0, cocpu_data_oe}, {7'b0, cocpu_sel & cocpu_r_w});
      if (host_sel && host_r_w) checkOutput("host_rd_model", host_data_out, modelRead(1'b1, host_addr));
      if (cocpu_sel && cocpu_r_w) checkOutput("cocpu_rd_model", cocpu_data_out, modelRead(1'b0, cocpu_addr));
    end
  end

  task automatic applyStimulus(input logic hs, input logic [1:0] ha, input logic hrw, input logic [7:0] hd,
                               input logic cs, input logic [1:0] ca, input logic crw, input logic [7:0] cd);
    @(posedge clock_cpu);
    #1;
    host_sel = hs;  host_addr = ha;  host_r_w = hrw;  host_data_in = hd;
    cocpu_sel = cs; cocpu_addr = ca; cocpu_r_w = crw; cocpu_data_in = cd;
  endtask

  task automatic hostOp(input logic [1:0] a, input logic rw, input logic [7:0] d);
    applyStimulus(1'b1, a, rw, d, 1'b0, 2'd0, 1'b1, 8'h00);
  endtask

  task automatic cocpuOp(input logic [1:0] a, input logic rw, input logic [7:0] d);
    applyStimulus(1'b0, 2'd0, 1'b1, 8'h00, 1'b1, a, rw, d);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b1, 8'h00);
  endtask

  task automatic expectHost(input string n, input logic [7:0] e);
    #2;
    checkOutput(n, host_data_out, e);
  endtask

  task automatic expectCocpu(input string n, input logic [7:0] e);
    #2;
    checkOutput(n, cocpu_data_out, e);
  endtask

  task automatic expectIrq(input logic eCocpu, input logic eHost);
    checkOutput("lit_irq_cocpu", {7'b0, _irq_cocpu}, {7'b0, eCocpu});
    checkOutput("lit_irq_host", {7'b0, _irq_host}, {7'b0, eHost});
  endtask

  initial begin
    logic [1:0] order [4];
    order = '{2'd1, 2'd2, 2'd3, 2'd0};
    repeat (3) @(posedge clock_cpu);
    @(negedge clock_cpu);
    _reset_cpu = 1'b1;
    compareOn  = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, order[i], 1'b1, 8'h00, 1'b1, order[i], 1'b1, 8'h00);
      expectHost("rst_host_reg", 8'h00);
      expectCocpu("rst_cocpu_reg", 8'h00);
    end
    expectIrq(1'b1, 1'b1);
    applyStimulus(1'b1, 2'd1, 1'b1, 8'h00, 1'b1, 2'd1, 1'b1, 8'h00);
    expectHost("host_status_uf", 8'h04);
    expectCocpu("cocpu_status_uf", 8'h04);
    applyStimulus(1'b1, 2'd1, 1'b1, 8'h00, 1'b1, 2'd1, 1'b1, 8'h00);
    expectHost("host_status_clr", 8'h00);
    expectCocpu("cocpu_status_clr", 8'h00);

    cocpuOp(2'd2, 1'b0, 8'h02);
    hostOp(2'd0, 1'b0, 8'h11);
    hostOp(2'd0, 1'b0, 8'h22);
    #2 expectIrq(1'b0, 1'b1);
    hostOp(2'd0, 1'b0, 8'h33);
    cocpuOp(2'd3, 1'b1, 8'h00);
    expectCocpu("cocpu_count3", 8'h03);
    cocpuOp(2'd0, 1'b1, 8'h00); expectCocpu("pop_11", 8'h11);
    cocpuOp(2'd0, 1'b1, 8'h00); expectCocpu("pop_22", 8'h22);
    cocpuOp(2'd0, 1'b1, 8'h00); expectCocpu("pop_33", 8'h33);
    idle();
    #2 expectIrq(1'b1, 1'b1);

    for (int i = 0; i < 17; i++) hostOp(2'd0, 1'b0, 8'(i));
    hostOp(2'd1, 1'b1, 8'h00); expectHost("host_status_full_ovf", 8'h0A);
    hostOp(2'd1, 1'b1, 8'h00); expectHost("host_status_full", 8'h02);
    for (int i = 0; i < 16; i++) begin
      cocpuOp(2'd0, 1'b1, 8'h00);
      expectCocpu("pop_seq", 8'(i));
    end
    cocpuOp(2'd0, 1'b1, 8'h00); expectCocpu("pop_empty", 8'h00);
    cocpuOp(2'd1, 1'b1, 8'h00); expectCocpu("cocpu_status_uf_en", 8'h84);
    hostOp(2'd1, 1'b1, 8'h00);  expectHost("host_status_drained", 8'h00);

    for (int i = 0; i < 16; i++) hostOp(2'd0, 1'b0, 8'h40 + 8'(i));
    applyStimulus(1'b1, 2'd0, 1'b0, 8'h5A, 1'b1, 2'd0, 1'b1, 8'h00);
    expectCocpu("full_push_pop_head", 8'h40);
    cocpuOp(2'd3, 1'b1, 8'h00); expectCocpu("full_count", 8'h10);
    hostOp(2'd1, 1'b1, 8'h00);  expectHost("no_ovf_status", 8'h02);
    cocpuOp(2'd1, 1'b1, 8'h00); expectCocpu("cocpu_status_full_rx", 8'h81);

    cocpuOp(2'd2, 1'b0, 8'h03);
    cocpuOp(2'd3, 1'b1, 8'h00); expectCocpu("count_after_flush", 8'h00);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 2'd0, 1'b0, 8'hB0 + 8'(i), 1'b1, 2'd0, 1'b0, 8'hC0 + 8'(i));
    applyStimulus(1'b1, 2'd3, 1'b1, 8'h00, 1'b1, 2'd3, 1'b1, 8'h00);
    expectHost("host_count4", 8'h04);
    expectCocpu("cocpu_count4", 8'h04);
    applyStimulus(1'b1, 2'd2, 1'b0, 8'h01, 1'b1, 2'd0, 1'b0, 8'hA5);
    applyStimulus(1'b1, 2'd3, 1'b1, 8'h00, 1'b1, 2'd3, 1'b1, 8'h00);
    expectHost("host_count_flushed", 8'h00);
    expectCocpu("cocpu_count_flushed", 8'h00);
    applyStimulus(1'b1, 2'd1, 1'b1, 8'h00, 1'b1, 2'd1, 1'b1, 8'h00);
    expectHost("host_status_flushed", 8'h00);
    expectCocpu("cocpu_status_flushed", 8'h80);
    cocpuOp(2'd0, 1'b1, 8'h00); expectCocpu("a5_lost", 8'h00);

    hostOp(2'd2, 1'b0, 8'h02);
    for (int i = 0; i < 3; i++) cocpuOp(2'd0, 1'b0, 8'h70 + 8'(i));
    hostOp(2'd0, 1'b0, 8'h99);
    idle();
    #2 expectIrq(1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1, 8'h00, 1'b1, 2'd2, 1'b1, 8'h00);
    #1 checkOutput("pre_reset_host_count", host_data_out, 8'h03);
    checkOutput("pre_reset_cocpu_ctrl", cocpu_data_out, 8'h02);
    #1 _reset_cpu = 1'b0;
    #1 expectIrq(1'b1, 1'b1);
    checkOutput("reset_host_count", host_data_out, 8'h00);
    checkOutput("reset_cocpu_ctrl", cocpu_data_out, 8'h00);
    repeat (2) @(negedge clock_cpu);
    #2 _reset_cpu = 1'b1;
    hostOp(2'd2, 1'b1, 8'h00);  expectHost("post_reset_ctrl", 8'h00);
    cocpuOp(2'd3, 1'b1, 8'h00); expectCocpu("post_reset_count", 8'h00);
    idle();
    idle();
    @(negedge clock_cpu);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
